mu01_loader: RTL and testbench

MU01_LOADER -- requirements
Module: mu01_loader

---
 rtl/mu01_loader.sv | 147 ++++++++++++++
 tb/tb_mu01_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu01_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mu01_loader
//  Purpose  : Byte-stream program loader. Receives a 16-bit word count and
//             then that many 16-bit words (high byte first) and writes the
//             words into processor memory starting at START_ADDR. The
//             processor is held in reset until the last word has been
//             written. A count of zero, or a count too large for the memory,
//             parks the loader in a sticky error state.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             in_valid/in_data/in_ready - byte input handshake
//             mem_we/mem_addr/mem_wdata - one-cycle memory write port
//             cpu_reset       - processor reset, released when loading is done
//             done / err      - sticky completion / bad-header flags
//  Revision : 1.0 - initial release
// ============================================================================
module mu01_loader #(
    parameter int ADDR_W     = 12,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_H  = 3'd0,
        S_LEN_L  = 3'd1,
        S_DATA_H = 3'd2,
        S_DATA_L = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Largest legal count; 17 bits so a full 2^16-word memory is representable.
    localparam logic [16:0]       c_MAX_COUNT  = 17'((1 << ADDR_W) - START_ADDR);
    localparam logic [ADDR_W-1:0] c_START_ADDR = ADDR_W'(START_ADDR);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_len_hi;
    logic [7:0]         r_data_hi;
    logic [15:0]        r_remain;
    logic [ADDR_W-1:0]  r_wofs;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [15:0]        r_mem_wdata;
    logic               r_done;
    logic               r_cpu_reset;

    logic               w_in_ready;
    logic               w_accept;
    logic [15:0]        w_count;
    logic               w_count_ok;
    logic               w_last_word;

    assign w_in_ready  = (r_state == S_LEN_H)  || (r_state == S_LEN_L) ||
                         (r_state == S_DATA_H) || (r_state == S_DATA_L);
    assign w_accept    = in_valid && w_in_ready;
    assign w_count     = {r_len_hi, in_data};
    assign w_count_ok  = (w_count != 16'd0) && ({1'b0, w_count} <= c_MAX_COUNT);
    assign w_last_word = (r_remain == 16'd1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LEN_H;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN_H:  if (w_accept) w_state_nxt = S_LEN_L;
            S_LEN_L:  if (w_accept) w_state_nxt = w_count_ok ? S_DATA_H : S_ERR;
            S_DATA_H: if (w_accept) w_state_nxt = S_DATA_L;
            S_DATA_L: if (w_accept) w_state_nxt = w_last_word ? S_DONE : S_DATA_H;
            S_DONE:   w_state_nxt = S_DONE;
            S_ERR:    w_state_nxt = S_ERR;
            default:  w_state_nxt = S_LEN_H;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte capture, word counters and the memory write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_hi    <= 8'd0;
            r_data_hi   <= 8'd0;
            r_remain    <= 16'd0;
            r_wofs      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= c_START_ADDR;
            r_mem_wdata <= 16'd0;
            r_done      <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_LEN_H:  r_len_hi  <= in_data;
                    S_LEN_L:  r_remain  <= w_count;
                    S_DATA_H: r_data_hi <= in_data;
                    S_DATA_L: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= c_START_ADDR + r_wofs;
                        r_mem_wdata <= {r_data_hi, in_data};
                        // Wraps only after the final word, when it is never used again.
                        r_wofs      <= r_wofs + 1'b1;
                        r_remain    <= r_remain - 16'd1;
                    end
                    default: ;
                endcase
            end
            // DONE is entered on the final accept, so these follow one cycle
            // later: the release lands right after the last write strobe.
            r_done      <= (r_state == S_DONE);
            r_cpu_reset <= (r_state != S_DONE);
        end
    end

    assign in_ready  = w_in_ready;
    assign err       = (r_state == S_ERR);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign cpu_reset = r_cpu_reset;

endmodule
`default_nettype wire

// File: tb/tb_mu01_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mu01_loader
//  Purpose  : Self-checking bench for mu01_loader. Byte streams are driven
//             with fixed or random idle gaps; every observed write and the
//             final flag state are compared against a stream-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mu01_loader;

    localparam int ADDR_W     = 12;
    localparam int START_ADDR = 0;
    localparam int DEPTH      = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        int                cyc;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              err;

    mu01_loader #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Monitor: write log, done-rise time, hold-when-idle violations
    // ------------------------------------------------------------------
    wr_t               obs[$];
    int                cyc = 0;
    int                done_cyc = -1;
    int                hold_bad = 0;
    logic              prev_done = 1'b0;
    logic              reset_seen = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [15:0]       prev_wdata = '0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        reset_seen <= reset;
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs.push_back('{mem_addr, mem_wdata, cyc});
        end else if (!reset_seen && (mem_addr !== prev_addr || mem_wdata !== prev_wdata)) begin
            hold_bad++;
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        prev_done  = done;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    // ------------------------------------------------------------------
    // Drivers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        idle(gap);
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each byte.
    task automatic send_stream(input byte_q_t b, input int gap, output int n_acc);
        bit ok;
        int g;
        n_acc = 0;
        foreach (b[i]) begin
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            send_byte(b[i], g, ok);
            if (!ok) break;
            n_acc++;
        end
    endtask

    task automatic clear_log();
        obs.delete();
        done_cyc = -1;
        hold_bad = 0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: interpret the whole byte stream at once
    // ------------------------------------------------------------------
    task automatic check_run(input string tag, input byte_q_t b, input int n_acc);
        int count, avail, nw, exp_acc;
        bit valid, exp_done, exp_err;
        count    = {16'd0, b[0], b[1]};
        valid    = (count >= 1) && (count <= DEPTH - START_ADDR);
        avail    = (b.size() - 2) / 2;
        nw       = valid ? ((avail < count) ? avail : count) : 0;
        exp_done = valid && (avail >= count);
        exp_err  = !valid;
        exp_acc  = valid ? 2 + ((b.size() - 2 < 2 * count) ? b.size() - 2 : 2 * count) : 2;

        check({tag, " accepted"}, n_acc, exp_acc);
        check({tag, " writes"}, obs.size(), nw);
        for (int k = 0; k < nw && k < obs.size(); k++) begin
            check($sformatf("%s addr[%0d]", tag, k), obs[k].addr, START_ADDR + k);
            check($sformatf("%s data[%0d]", tag, k), obs[k].data, {b[2 + 2 * k], b[3 + 2 * k]});
        end
        check({tag, " done"}, done, exp_done);
        check({tag, " err"}, err, exp_err);
        check({tag, " cpu_reset"}, cpu_reset, !exp_done);
        check({tag, " in_ready"}, in_ready, !(exp_done || exp_err));
        check({tag, " hold"}, hold_bad, 0);
        if (exp_done && obs.size() > 0)
            check({tag, " done timing"}, done_cyc, obs[obs.size() - 1].cyc + 1);
    endtask

    task automatic run(input string tag, input byte_q_t b, input int gap);
        int n_acc;
        do_reset();
        clear_log();
        send_stream(b, gap, n_acc);
        idle(4);
        check_run(tag, b, n_acc);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        byte_q_t b;
        int      n_acc;
        int      cnt;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst in_ready", in_ready, 1'b1);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_addr", mem_addr, START_ADDR);
        check("rst mem_wdata", mem_wdata, 16'h0000);
        check("rst cpu_reset", cpu_reset, 1'b1);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);

        // Reference program, back-to-back and with 3 idle cycles per byte
        b = '{8'h00, 8'h03, 8'h80, 8'h05, 8'hA0, 8'h01, 8'h70, 8'h00};
        run("b2b", b, 0);
        run("gap3", b, 3);

        // Zero count: error, processor stays in reset
        b = '{8'h00, 8'h00};
        run("len0", b, 0);
        idle(20);
        check("len0 cpu_reset+20", cpu_reset, 1'b1);
        check("len0 err+20", err, 1'b1);
        check("len0 writes+20", obs.size(), 0);

        // One past capacity
        b = '{8'h10, 8'h01};
        run("len4097", b, 1);

        // Random oversize count
        cnt = int'($urandom_range(16'hFFFF, DEPTH + 1));
        b = '{8'(cnt >> 8), 8'(cnt)};
        run("lenbig", b, -1);

        // Random programs, some with trailing bytes the loader must refuse
        for (int t = 0; t < 8; t++) begin
            cnt = int'($urandom_range(24, 1));
            b = '{8'(cnt >> 8), 8'(cnt)};
            for (int i = 0; i < 2 * cnt + ((t % 3 == 0) ? 3 : 0); i++) b.push_back(8'($urandom));
            run($sformatf("rand%0d", t), b, -1);
        end

        // Full memory
        b = '{8'h10, 8'h00};
        for (int i = 0; i < 2 * DEPTH; i++) b.push_back(8'($urandom));
        run("full", b, 0);
        check("full last addr", obs.size() > 0 ? obs[obs.size() - 1].addr : 'x, DEPTH - 1);

        // Reset mid-load, then a fresh load
        do_reset();
        clear_log();
        b = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_stream(b, 0, n_acc);
        idle(2);
        do_reset();
        b = '{8'h00, 8'h01, 8'h56, 8'h78};
        send_stream(b, 0, n_acc);
        idle(4);
        check("abort writes", obs.size(), 2);
        if (obs.size() == 2) begin
            check("abort w0 addr", obs[0].addr, START_ADDR);
            check("abort w0 data", obs[0].data, 16'h1234);
            check("abort w1 addr", obs[1].addr, START_ADDR);
            check("abort w1 data", obs[1].data, 16'h5678);
        end
        check("abort done", done, 1'b1);
        check("abort cpu_reset", cpu_reset, 1'b0);

        // Reset on the same edge as a DATA_L accept suppresses the write
        do_reset();
        clear_log();
        b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        send_stream(b, 0, n_acc);
        in_valid = 1'b1;
        in_data  = 8'h78;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("supp mem_we", mem_we, 1'b0);
        check("supp mem_addr", mem_addr, START_ADDR);
        check("supp mem_wdata", mem_wdata, 16'h0000);
        check("supp cpu_reset", cpu_reset, 1'b1);
        check("supp done", done, 1'b0);
        check("supp err", err, 1'b0);
        check("supp in_ready", in_ready, 1'b1);
        idle(3);
        check("supp writes", obs.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
